sram_1rw_arb_ctrl: RTL and testbench



---
 rtl/sram_1rw_arb_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_1rw_arb_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_arb_ctrl.sv
// Zero-fill sequencer and write-priority arbiter for a single-port
// masked SRAM macro; reads are guaranteed a slot after a bounded run of writes.
`timescale 1ns/1ps
module sram_1rw_arb_ctrl #(
  parameter int DEPTH        = 512,
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 210,
  parameter int MASK_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              starved;
  logic              in_init;
  logic              gnt_w;
  logic              gnt_r;

  assign in_init = (state == INIT);
  assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign gnt_w   = !in_init && w_valid && !(r_valid && starved);
  assign gnt_r   = !in_init && r_valid && !gnt_w;

  assign w_ready   = gnt_w;
  assign r_ready   = gnt_r;
  assign init_done = !in_init;
  assign resp_data = sram_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: begin
        if (init_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt   <= '0;
      starve_cnt <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= gnt_r;
      if (in_init) begin
        init_cnt <= init_cnt + 1'b1;
      end
      // a read slot or an idle read side both end the starvation run
      if (in_init || gnt_r || !r_valid) begin
        starve_cnt <= '0;
      end else if (gnt_w && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    unique case (1'b1)
      in_init: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
      end
      gnt_w: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = w_addr;
        sram_wmask = w_mask;
        sram_wdata = w_data;
      end
      gnt_r: begin
        sram_en    = 1'b1;
        sram_addr  = r_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_1rw_arb_ctrl.sv
// Bench for sram_1rw_arb_ctrl: behavioural macro model, directed
// stimulus, read responses checked against a queue of expected data.
`timescale 1ns/1ps
module tb_sram_1rw_arb_ctrl;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [8:0]   w_addr = '0;
  logic [9:0]   w_mask = '0;
  logic [209:0] w_data = '0;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [8:0]   r_addr = '0;
  logic         resp_valid;
  logic [209:0] resp_data;
  logic         init_done;
  logic         sram_en;
  logic         sram_wmode;
  logic [8:0]   sram_addr;
  logic [9:0]   sram_wmask;
  logic [209:0] sram_wdata;
  logic [209:0] sram_rdata = '0;

  logic [209:0] mem [512];
  logic [209:0] exp_q [$];
  int           total = 0;
  int           fails = 0;

  always #5 clock = ~clock;

  sram_1rw_arb_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_mask     (w_mask),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // macro model starts full of ones so the zero-fill is observable
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '1;
  end

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < 10; s++) begin
          if (sram_wmask[s]) mem[sram_addr][s*21 +: 21] <= sram_wdata[s*21 +: 21];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [209:0] act,
                     input logic [209:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 1'b1, 1'b0);
      end else begin
        chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic run_init(input string tag);
    int bad = 0;
    int rdy = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clock);
      if (!(sram_en && sram_wmode && sram_addr == 9'(i) &&
            sram_wmask == 10'h3ff && sram_wdata == '0)) bad++;
      if (w_ready || r_ready || init_done) rdy++;
      if (i == 511) begin
        w_valid = 1'b0;
        r_valid = 1'b0;
      end
      next_cycle();
    end
    chk({tag, "_fill_writes"}, 32'(bad), 0);
    chk({tag, "_ready_low"}, 32'(rdy), 0);
    @(negedge clock);
    chk({tag, "_init_done"}, init_done, 1'b1);
    chk({tag, "_idle_en"}, sram_en, 1'b0);
    next_cycle();
  endtask

  task automatic do_write(input logic [8:0] a, input logic [9:0] m,
                          input logic [209:0] d);
    w_valid = 1'b1;
    w_addr  = a;
    w_mask  = m;
    w_data  = d;
    @(negedge clock);
    chk("w_ready", w_ready, 1'b1);
    chk("w_issue", {sram_en, sram_wmode, sram_addr, sram_wmask},
        {1'b1, 1'b1, a, m});
    chk("w_wdata", sram_wdata, d);
    next_cycle();
    w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, input logic [209:0] e,
                         input bit push);
    r_valid = 1'b1;
    r_addr  = a;
    @(negedge clock);
    chk("r_ready", r_ready, 1'b1);
    chk("r_issue", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, a});
    if (push) exp_q.push_back(e);
    next_cycle();
    r_valid = 1'b0;
  endtask

  logic [209:0] d1;
  byte          g;

  initial begin
    d1 = {10{21'h0abcde}};
    w_valid = 1'b1;
    r_valid = 1'b1;
    w_addr  = 9'd33;
    w_mask  = '1;
    w_data  = '1;
    r_addr  = 9'd44;
    #3;
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_r_ready", r_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    @(posedge clock);
    next_cycle();
    reset_n = 1'b1;
    run_init("init1");

    do_write(9'd5, 10'h001, '1);
    do_read(9'd5, 210'h1fffff, 1'b1);
    next_cycle();

    // both sides saturated: four writes then one forced read
    w_valid = 1'b1;
    w_addr  = 9'd100;
    w_mask  = '1;
    w_data  = '0;
    r_valid = 1'b1;
    r_addr  = 9'd200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      g = w_ready ? "W" : (r_ready ? "R" : "-");
      chk($sformatf("grant_%0d", i), 8'(g), (i % 5 == 4) ? 8'("R") : 8'("W"));
      if (w_ready && r_ready) chk("grant_both", 1'b1, 1'b0);
      if (r_ready) exp_q.push_back('0);
      next_cycle();
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
    next_cycle();

    do_write(9'd1, 10'h3ff, d1);
    do_write(9'd2, 10'h000, '1);
    do_read(9'd0, '0, 1'b1);
    do_read(9'd1, d1, 1'b1);
    do_read(9'd2, '0, 1'b1);
    next_cycle();

    do_write(9'd7, 10'h3ff, 210'h3);
    do_read(9'd7, 210'h3, 1'b1);
    next_cycle();
    next_cycle();
    chk("sb_drained_1", 32'(exp_q.size()), 0);

    // reset lands while a read response is in flight
    r_valid = 1'b1;
    r_addr  = 9'd5;
    @(negedge clock);
    chk("pre_rst_r_ready", r_ready, 1'b1);
    next_cycle();
    r_valid = 1'b0;
    chk("inflight_resp", resp_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    run_init("init2");

    do_read(9'd5, '0, 1'b1);
    next_cycle();
    next_cycle();
    chk("sb_drained_2", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
